// File: rtl/bcd_digit_counter.sv
// Four-digit BCD up/down counter with built-in tick prescaler, feeding per-digit
// seven-segment decoders with 5-bit codes (5'b0_dddd = digit, 5'b10000 = blank).
module bcd_digit_counter #(
  parameter int TICK_DIV = 50_000_000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        up_dn,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [4:0]  hex0,
  output logic [4:0]  hex1,
  output logic [4:0]  hex2,
  output logic [4:0]  hex3,
  output logic        tick_out,
  output logic        wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [4:0] BLANK = 5'b10000;
  localparam logic [4:0] LZ_RESET = BLANK_LZ ? BLANK : 5'b00000;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic [4:0]    hex0_q, hex0_d;
  logic [4:0]    hex1_q, hex1_d;
  logic [4:0]    hex2_q, hex2_d;
  logic [4:0]    hex3_q, hex3_d;
  logic          tick;
  logic          carry;
  logic [3:0]    dig;

  // clear/load restart the prescaler and swallow any tick landing in the same cycle
  always_comb begin
    tick   = run && (pcnt_q == PMAX) && !clear && !load;
    tick_d = tick;
    pcnt_d = pcnt_q;
    if (clear || load) begin
      pcnt_d = '0;
    end else if (run) begin
      pcnt_d = (pcnt_q == PMAX) ? '0 : pcnt_q + PONE;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    carry  = 1'b1;
    dig    = '0;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      for (int i = 0; i < 4; i++) begin
        dig = load_val[4*i +: 4];
        cnt_d[4*i +: 4] = (dig > 4'd9) ? 4'd0 : dig;
      end
    end else if (tick) begin
      // carry/borrow ripples upward; surviving past the top digit is a wrap
      for (int i = 0; i < 4; i++) begin
        dig = cnt_q[4*i +: 4];
        if (carry) begin
          if (up_dn) begin
            if (dig == 4'd9) begin
              cnt_d[4*i +: 4] = 4'd0;
            end else begin
              cnt_d[4*i +: 4] = dig + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (dig == 4'd0) begin
              cnt_d[4*i +: 4] = 4'd9;
            end else begin
              cnt_d[4*i +: 4] = dig - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
      wrap_d = carry;
    end
  end

  always_comb begin
    hex0_d = {1'b0, cnt_q[3:0]};
    hex1_d = (BLANK_LZ && (cnt_q[15:4] == '0))  ? BLANK : {1'b0, cnt_q[7:4]};
    hex2_d = (BLANK_LZ && (cnt_q[15:8] == '0))  ? BLANK : {1'b0, cnt_q[11:8]};
    hex3_d = (BLANK_LZ && (cnt_q[15:12] == '0)) ? BLANK : {1'b0, cnt_q[15:12]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt_q <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      hex0_q <= 5'b00000;
      hex1_q <= LZ_RESET;
      hex2_q <= LZ_RESET;
      hex3_q <= LZ_RESET;
    end else begin
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      hex0_q <= hex0_d;
      hex1_q <= hex1_d;
      hex2_q <= hex2_d;
      hex3_q <= hex3_d;
    end
  end

  assign hex0     = hex0_q;
  assign hex1     = hex1_q;
  assign hex2     = hex2_q;
  assign hex3     = hex3_q;
  assign tick_out = tick_q;
  assign wrap     = wrap_q;

endmodule
